bp_resolve_ctrl: RTL and testbench

- Branch-prediction controller for the fetch/AD pipeline.
- Owns a direct-mapped branch target buffer (BTB) of 2-bit saturating counters and provides combinational predictions to fetch.
- Consumes resolved branch info from the AD latch outputs, updates the BTB, and on a mispredict issues a PC redirect and a multi-cycle flush.
- Drives the global stage enable for all stage latches.

---
 rtl/bp_resolve_ctrl_pkg.sv | 25 ++
 rtl/bp_btb_array.sv | 51 +++++
 rtl/bp_resolve_ctrl.sv | 140 ++++++++++++++
 tb/tb_bp_resolve_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bp_resolve_ctrl_pkg.sv
// Shared encodings for the branch-prediction controller: branch flags,
// 2-bit counter values, FSM states and the saturating counter step.
package bp_resolve_ctrl_pkg;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_NT   = 2'b01;
  localparam logic [1:0] BR_T    = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } bp_state_e;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST)  ? ST  : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_btb_array.sv
// Direct-mapped BTB storage: combinational tagged read port, one synchronous
// write port, everything cleared by the asynchronous reset.
module bp_btb_array #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 26
) (
  input  logic             stg_clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic [31:0]      rd_target,
  output logic [1:0]       rd_counter,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target,
  input  logic [1:0]       wr_counter
);

  logic             valid_q   [ENTRIES];
  logic [TAG_W-1:0] tag_q     [ENTRIES];
  logic [31:0]      target_q  [ENTRIES];
  logic [1:0]       counter_q [ENTRIES];

  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]   <= 1'b0;
        tag_q[i]     <= '0;
        target_q[i]  <= '0;
        counter_q[i] <= 2'b00;
      end
    end else if (wr_en) begin
      valid_q[wr_idx]   <= wr_valid;
      tag_q[wr_idx]     <= wr_tag;
      target_q[wr_idx]  <= wr_target;
      counter_q[wr_idx] <= wr_counter;
    end
  end

  // Miss reads return zeros so the prediction outputs need no extra gating.
  always_comb begin
    rd_hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd_target  = rd_hit ? target_q[rd_idx]  : 32'h0;
    rd_counter = rd_hit ? counter_q[rd_idx] : 2'b00;
  end

endmodule

// File: rtl/bp_resolve_ctrl.sv
// Branch-prediction controller: BTB lookup for fetch, BTB update from the AD
// resolution slot, mispredict redirect and multi-cycle flush sequencing.
module bp_resolve_ctrl
  import bp_resolve_ctrl_pkg::*;
#(
  parameter int ENTRIES      = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        stg_clk,
  input  logic        reset,
  input  logic        stg_stall,
  input  logic [31:0] fetch_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [1:0]  pred_counter,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic [31:0] res_target,
  input  logic [1:0]  res_flag_branch,
  input  logic [31:0] res_fallthrough,
  input  logic [1:0]  res_counter,
  input  logic        res_hit,
  input  logic        res_pred_taken,
  input  logic [31:0] res_pred_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        stg_ena
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  bp_state_e   state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic        redirect_q, redirect_nx;
  logic [31:0] rpc_q, rpc_nx;

  logic             sample, act_taken, mispredict;
  logic             wr_en, wr_valid;
  logic [TAG_W-1:0] wr_tag;
  logic [31:0]      wr_target;
  logic [1:0]       wr_counter;
  logic [1:0]       unused_pc_lsbs;

  assign unused_pc_lsbs = fetch_pc[1:0] ^ res_pc[1:0];

  bp_btb_array #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_btb (
    .stg_clk    (stg_clk),
    .reset      (reset),
    .rd_idx     (fetch_pc[IDX_W+1:2]),
    .rd_tag     (fetch_pc[31:IDX_W+2]),
    .rd_hit     (pred_hit),
    .rd_target  (pred_target),
    .rd_counter (pred_counter),
    .wr_en      (wr_en),
    .wr_idx     (res_pc[IDX_W+1:2]),
    .wr_valid   (wr_valid),
    .wr_tag     (wr_tag),
    .wr_target  (wr_target),
    .wr_counter (wr_counter)
  );

  assign pred_taken  = pred_hit & pred_counter[1];
  assign stg_ena     = ~stg_stall;
  assign flush       = (state_q == S_FLUSH);
  assign redirect    = redirect_q;
  assign redirect_pc = rpc_q;

  assign act_taken  = res_flag_branch[1];
  assign sample     = res_valid & (state_q == S_RUN) & ~stg_stall;
  assign mispredict = sample & ((act_taken != res_pred_taken) |
                      (act_taken & res_pred_taken & (res_target != res_pred_target)));

  // Hit updates reuse the captured counter/target rather than re-reading the array.
  always_comb begin
    wr_en      = 1'b0;
    wr_valid   = 1'b0;
    wr_tag     = '0;
    wr_target  = 32'h0;
    wr_counter = SNT;
    if (sample) begin
      if (res_flag_branch != BR_NONE) begin
        if (res_hit || act_taken) begin
          wr_en     = 1'b1;
          wr_valid  = 1'b1;
          wr_tag    = res_pc[31:IDX_W+2];
          wr_target = act_taken ? res_target : res_pred_target;
          if (res_flag_branch == BR_JMP) wr_counter = ST;
          else if (res_hit)              wr_counter = ctr_next(res_counter, act_taken);
          else                           wr_counter = WT;
        end
      end else if (res_hit) begin
        wr_en = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx    = state_q;
    cnt_nx      = cnt_q;
    redirect_nx = redirect_q;
    rpc_nx      = rpc_q;
    if (!stg_stall) begin
      redirect_nx = 1'b0;
      case (state_q)
        S_RUN: begin
          if (mispredict) begin
            redirect_nx = 1'b1;
            rpc_nx      = act_taken ? res_target : res_fallthrough;
            cnt_nx      = CNT_W'(FLUSH_CYCLES - 1);
            state_nx    = S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (cnt_q == '0) state_nx = S_RUN;
          else             cnt_nx   = cnt_q - CNT_W'(1);
        end
        default: state_nx = S_RUN;
      endcase
    end
  end

  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RUN;
      cnt_q      <= '0;
      redirect_q <= 1'b0;
      rpc_q      <= 32'h0;
    end else begin
      state_q    <= state_nx;
      cnt_q      <= cnt_nx;
      redirect_q <= redirect_nx;
      rpc_q      <= rpc_nx;
    end
  end

endmodule

// File: tb/tb_bp_resolve_ctrl.sv
// Bench for bp_resolve_ctrl: redirect targets go through a scoreboard queue,
// lookups and flush timing are checked directly.
module tb_bp_resolve_ctrl;
  import bp_resolve_ctrl_pkg::*;

  logic        stg_clk = 1'b0;
  logic        reset;
  logic        stg_stall;
  logic [31:0] fetch_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  pred_counter;
  logic        res_valid;
  logic [31:0] res_pc, res_target, res_fallthrough, res_pred_target;
  logic [1:0]  res_flag_branch, res_counter;
  logic        res_hit, res_pred_taken;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush, stg_ena;

  int n_checks = 0;
  int n_pass   = 0;
  int rd_seen  = 0;
  logic [31:0] exp_q[$];

  bp_resolve_ctrl #(.ENTRIES(16), .FLUSH_CYCLES(2)) dut (
    .stg_clk(stg_clk), .reset(reset), .stg_stall(stg_stall), .fetch_pc(fetch_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_counter(pred_counter), .res_valid(res_valid), .res_pc(res_pc),
    .res_target(res_target), .res_flag_branch(res_flag_branch),
    .res_fallthrough(res_fallthrough), .res_counter(res_counter), .res_hit(res_hit),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .stg_ena(stg_ena)
  );

  always #5 stg_clk = ~stg_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge stg_clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic tk, input logic [31:0] tgt, input logic [1:0] cnt);
    fetch_pc = pc;
    #1;
    chk({tag, "_hit"}, 32'(pred_hit), 32'(hit));
    chk({tag, "_taken"}, 32'(pred_taken), 32'(tk));
    chk({tag, "_target"}, pred_target, tgt);
    chk({tag, "_counter"}, 32'(pred_counter), 32'(cnt));
  endtask

  // track=1: the DUT will sample this slot, so a mispredict queues its redirect PC.
  task automatic drive_res(input logic [31:0] pc, input logic [1:0] flag,
                           input logic [31:0] tgt, input logic [31:0] fall,
                           input logic [1:0] cnt, input logic hit, input logic pt,
                           input logic [31:0] ptgt, input bit track);
    logic act;
    res_valid = 1'b1; res_pc = pc; res_flag_branch = flag; res_target = tgt;
    res_fallthrough = fall; res_counter = cnt; res_hit = hit;
    res_pred_taken = pt; res_pred_target = ptgt;
    act = flag[1];
    if (track && ((act != pt) || (act && pt && tgt != ptgt)))
      exp_q.push_back(act ? tgt : fall);
  endtask

  // Scoreboard consumer: a redirect counts on its unstalled cycle.
  always @(negedge stg_clk) begin
    if (!reset && redirect && !stg_stall) begin
      rd_seen++;
      if (exp_q.size() == 0) chk("redirect_unexpected", 32'(redirect), 32'd0);
      else                   chk("redirect_pc", redirect_pc, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nflush;
    reset = 1'b1; stg_stall = 1'b0; fetch_pc = 32'h40; res_valid = 1'b0;
    res_pc = '0; res_target = '0; res_fallthrough = '0; res_pred_target = '0;
    res_flag_branch = BR_NONE; res_counter = SNT; res_hit = 1'b0; res_pred_taken = 1'b0;
    #12;
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    reset = 1'b0;
    tick();

    // 1: empty BTB
    look("t1", 32'h40, 1'b0, 1'b0, 32'h0, SNT);
    chk("t1_stg_ena", 32'(stg_ena), 32'd1);
    chk("t1_flush", 32'(flush), 32'd0);

    // 2: taken miss allocates and redirects; same-cycle lookup still sees old contents
    drive_res(32'h40, BR_T, 32'h100, 32'h44, SNT, 1'b0, 1'b0, 32'h0, 1'b1);
    look("t2_pre", 32'h40, 1'b0, 1'b0, 32'h0, SNT);
    tick();
    res_valid = 1'b0;
    chk("t2_redirect", 32'(redirect), 32'd1);
    chk("t2_flush1", 32'(flush), 32'd1);
    look("t2_post", 32'h40, 1'b1, 1'b1, 32'h100, WT);
    tick();
    chk("t2_redirect_off", 32'(redirect), 32'd0);
    chk("t2_flush2", 32'(flush), 32'd1);
    tick();
    chk("t2_flush_end", 32'(flush), 32'd0);

    // 3: correct taken predictions saturate the counter
    drive_res(32'h40, BR_T, 32'h100, 32'h44, WT, 1'b1, 1'b1, 32'h100, 1'b1);
    tick();
    res_valid = 1'b0;
    chk("t3_no_redirect", 32'(redirect), 32'd0);
    look("t3a", 32'h40, 1'b1, 1'b1, 32'h100, ST);
    drive_res(32'h40, BR_T, 32'h100, 32'h44, ST, 1'b1, 1'b1, 32'h100, 1'b1);
    tick();
    res_valid = 1'b0;
    chk("t3_flush", 32'(flush), 32'd0);
    look("t3b", 32'h40, 1'b1, 1'b1, 32'h100, ST);

    // 4: not-taken mispredict; wrong-path slots in the flush window are ignored
    drive_res(32'h40, BR_NT, 32'h100, 32'h44, ST, 1'b1, 1'b1, 32'h100, 1'b1);
    tick();
    chk("t4_redirect", 32'(redirect), 32'd1);
    drive_res(32'h40, BR_NONE, 32'h0, 32'h44, WT, 1'b1, 1'b0, 32'h100, 1'b0);
    tick();
    chk("t4_flush2", 32'(flush), 32'd1);
    drive_res(32'h84, BR_T, 32'h300, 32'h88, SNT, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    res_valid = 1'b0;
    chk("t4_flush_end", 32'(flush), 32'd0);
    look("t4_40", 32'h40, 1'b1, 1'b1, 32'h100, WT);
    look("t4_84", 32'h84, 1'b0, 1'b0, 32'h0, SNT);

    // 5: stall freezes sampling; redirect holds through a stall; flush length unchanged
    stg_stall = 1'b1;
    drive_res(32'h84, BR_T, 32'h200, 32'h88, SNT, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    chk("t5_stg_ena", 32'(stg_ena), 32'd0);
    tick(); tick();
    chk("t5_stall_redirect", 32'(redirect), 32'd0);
    chk("t5_stall_flush", 32'(flush), 32'd0);
    look("t5_stall_84", 32'h84, 1'b0, 1'b0, 32'h0, SNT);
    stg_stall = 1'b0;
    tick();
    res_valid = 1'b0;
    chk("t5_redirect", 32'(redirect), 32'd1);
    stg_stall = 1'b1;
    tick(); tick();
    chk("t5_redirect_held", 32'(redirect), 32'd1);
    chk("t5_flush_held", 32'(flush), 32'd1);
    stg_stall = 1'b0;
    nflush = 0;
    for (int i = 0; i < 10 && flush; i++) begin
      nflush++;
      tick();
    end
    chk("t5_flush_len", 32'(nflush), 32'd2);
    chk("t5_redirect_done", 32'(redirect), 32'd0);
    look("t5_84", 32'h84, 1'b1, 1'b1, 32'h200, WT);

    // 6: reset during FLUSH clears outputs and BTB at once
    drive_res(32'h84, BR_NT, 32'h200, 32'h88, WT, 1'b1, 1'b1, 32'h200, 1'b1);
    tick();
    res_valid = 1'b0;
    chk("t6_flush", 32'(flush), 32'd1);
    stg_stall = 1'b1;
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk("t6_flush_rst", 32'(flush), 32'd0);
    chk("t6_redirect_rst", 32'(redirect), 32'd0);
    chk("t6_redirect_pc_rst", redirect_pc, 32'h0);
    chk("t6_stg_ena_stall", 32'(stg_ena), 32'd0);
    stg_stall = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    look("t6_40", 32'h40, 1'b0, 1'b0, 32'h0, SNT);
    look("t6_84", 32'h84, 1'b0, 1'b0, 32'h0, SNT);
    chk("t6_flush_after", 32'(flush), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("redirect_count", 32'(rd_seen), 32'd3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
